// File: rtl/label_ram_arb_pkg.sv
// Shared types for the label RAM arbiter: return-path owner tag and
// starvation counter width.
package label_ram_arb_pkg;

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_DISP = 2'd1,
        TAG_GAME = 2'd2
    } tag_t;

    localparam int STARVE_CNT_W = 8;

endpackage

// File: rtl/label_ram_arb_starve_cnt.sv
// Saturating count of consecutive cycles the game requester has been refused.
module label_ram_arb_starve_cnt
    import label_ram_arb_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    blocked,
    input  logic [STARVE_CNT_W-1:0] limit,
    output logic                    at_limit
);

    logic [STARVE_CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (blocked) begin
            if (cnt < limit) begin
                cnt <= cnt + STARVE_CNT_W'(1);
            end
        end else begin
            cnt <= '0;
        end
    end

    assign at_limit = (cnt == limit);

endmodule

// File: rtl/label_ram_arbiter.sv
// Single-port label RAM shared between the display stream (priority) and the
// game FSM; read data is routed back to its owner two cycles after the grant.
module label_ram_arbiter
    import label_ram_arb_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 16,
    parameter int STARVE_LIMIT = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  disp_req,
    input  logic [ADDR_WIDTH-1:0] disp_addr,
    output logic                  disp_gnt,
    output logic                  disp_rvalid,
    output logic [DATA_WIDTH-1:0] disp_rdata,
    input  logic                  game_req,
    input  logic                  game_we,
    input  logic [ADDR_WIDTH-1:0] game_addr,
    input  logic [DATA_WIDTH-1:0] game_wdata,
    output logic                  game_gnt,
    output logic                  game_rvalid,
    output logic [DATA_WIDTH-1:0] game_rdata,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);

    localparam logic [STARVE_CNT_W-1:0] LIMIT = STARVE_CNT_W'(STARVE_LIMIT);

    logic at_limit;
    logic blocked;
    tag_t tag_q;
    tag_t tag_d;

    // A starved game request wins even over an active display request.
    assign game_gnt = ~reset & game_req & (~disp_req | at_limit);
    assign disp_gnt = ~reset & disp_req & ~game_gnt;
    assign blocked  = game_req & ~game_gnt;

    label_ram_arb_starve_cnt u_starve_cnt (
        .clk      (clk),
        .reset    (reset),
        .blocked  (blocked),
        .limit    (LIMIT),
        .at_limit (at_limit)
    );

    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (disp_gnt) begin
            ram_en   = 1'b1;
            ram_addr = disp_addr;
        end else if (game_gnt) begin
            ram_en    = 1'b1;
            ram_we    = game_we;
            ram_addr  = game_addr;
            ram_wdata = game_wdata;
        end
    end

    always_comb begin
        tag_d = TAG_NONE;
        if (disp_gnt) begin
            tag_d = TAG_DISP;
        end else if (game_gnt && !game_we) begin
            tag_d = TAG_GAME;
        end
    end

    // Tag travels with the RAM's one-cycle read latency, then steers the data.
    always_ff @(posedge clk) begin
        if (reset) begin
            tag_q       <= TAG_NONE;
            disp_rvalid <= 1'b0;
            game_rvalid <= 1'b0;
            disp_rdata  <= '0;
            game_rdata  <= '0;
        end else begin
            tag_q       <= tag_d;
            disp_rvalid <= (tag_q == TAG_DISP);
            game_rvalid <= (tag_q == TAG_GAME);
            if (tag_q == TAG_DISP) begin
                disp_rdata <= ram_rdata;
            end
            if (tag_q == TAG_GAME) begin
                game_rdata <= ram_rdata;
            end
        end
    end

endmodule

// File: tb/tb_label_ram_arbiter.sv
// Directed and randomized checks of label_ram_arbiter against a transaction
// model (shadow memory, starvation count, return slot) plus a bench RAM.
module tb_label_ram_arbiter;

    localparam int DW    = 8;
    localparam int AW    = 16;
    localparam int LIMIT = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          disp_req;
    logic [AW-1:0] disp_addr;
    logic          disp_gnt;
    logic          disp_rvalid;
    logic [DW-1:0] disp_rdata;
    logic          game_req;
    logic          game_we;
    logic [AW-1:0] game_addr;
    logic [DW-1:0] game_wdata;
    logic          game_gnt;
    logic          game_rvalid;
    logic [DW-1:0] game_rdata;
    logic          ram_en;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    label_ram_arbiter #(
        .DATA_WIDTH   (DW),
        .ADDR_WIDTH   (AW),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .disp_req    (disp_req),
        .disp_addr   (disp_addr),
        .disp_gnt    (disp_gnt),
        .disp_rvalid (disp_rvalid),
        .disp_rdata  (disp_rdata),
        .game_req    (game_req),
        .game_we     (game_we),
        .game_addr   (game_addr),
        .game_wdata  (game_wdata),
        .game_gnt    (game_gnt),
        .game_rvalid (game_rvalid),
        .game_rdata  (game_rdata),
        .ram_en      (ram_en),
        .ram_we      (ram_we),
        .ram_addr    (ram_addr),
        .ram_wdata   (ram_wdata),
        .ram_rdata   (ram_rdata)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] ram [0:65535];

    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) ram[ram_addr] <= ram_wdata;
            else        ram_rdata     <= ram[ram_addr];
        end
    end

    typedef struct {
        bit            v;
        bit            disp;
        logic [DW-1:0] d;
    } ev_t;

    logic [DW-1:0] shadow [0:65535];
    int            m_starve;
    ev_t           pend;
    bit            e_dval, e_gval;
    logic [DW-1:0] e_drd, e_grd;
    bit            act_ggnt, act_dgnt;
    int            checks = 0;
    int            errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: inputs are already applied; checks at the negedge,
    // model advances at the posedge, returns 1 time unit after it.
    task automatic tick();
        bit  eg, ed;
        ev_t cur;
        eg = !reset && game_req && (!disp_req || m_starve == LIMIT);
        ed = !reset && disp_req && !eg;
        @(negedge clk);
        act_ggnt = game_gnt;
        act_dgnt = disp_gnt;
        chk("game_gnt", game_gnt, eg);
        chk("disp_gnt", disp_gnt, ed);
        chk("ram_en", ram_en, eg | ed);
        chk("ram_we", ram_we, eg & game_we);
        if (ed) chk("ram_addr_disp", ram_addr, disp_addr);
        if (eg) chk("ram_addr_game", ram_addr, game_addr);
        if (eg && game_we) chk("ram_wdata", ram_wdata, game_wdata);
        chk("disp_rvalid", disp_rvalid, e_dval);
        chk("disp_rdata", disp_rdata, e_drd);
        chk("game_rvalid", game_rvalid, e_gval);
        chk("game_rdata", game_rdata, e_grd);
        cur = '{v: 1'b0, disp: 1'b0, d: '0};
        if (ed) cur = '{v: 1'b1, disp: 1'b1, d: shadow[disp_addr]};
        else if (eg && !game_we) cur = '{v: 1'b1, disp: 1'b0, d: shadow[game_addr]};
        @(posedge clk);
        if (reset) begin
            pend     = '{v: 1'b0, disp: 1'b0, d: '0};
            e_dval   = 0;
            e_gval   = 0;
            e_drd    = '0;
            e_grd    = '0;
            m_starve = 0;
        end else begin
            e_dval = pend.v && pend.disp;
            e_gval = pend.v && !pend.disp;
            if (e_dval) e_drd = pend.d;
            if (e_gval) e_grd = pend.d;
            pend = cur;
            if (eg && game_we) shadow[game_addr] = game_wdata;
            if (game_req && !eg) m_starve = (m_starve + 1 > LIMIT) ? LIMIT : m_starve + 1;
            else                 m_starve = 0;
        end
        #1;
    endtask

    initial begin
        int first;
        bit dg_at_grant;

        for (int a = 0; a < 65536; a++) begin
            ram[a]    = a[7:0];
            shadow[a] = a[7:0];
        end
        m_starve   = 0;
        pend       = '{v: 1'b0, disp: 1'b0, d: '0};
        e_dval     = 0;
        e_gval     = 0;
        e_drd      = '0;
        e_grd      = '0;
        reset      = 1'b1;
        disp_req   = 1'b0;
        disp_addr  = '0;
        game_req   = 1'b0;
        game_we    = 1'b0;
        game_addr  = '0;
        game_wdata = '0;
        tick();
        tick();
        reset = 1'b0;

        // display streaming
        for (int i = 0; i < 10; i++) begin
            disp_req  = 1'b1;
            disp_addr = AW'(i);
            tick();
            chk("t1_disp_gnt", act_dgnt, 1'b1);
        end
        disp_req = 1'b0;
        tick();
        tick();
        chk("t1_last_rdata", disp_rdata, 8'd9);

        // game write then read back
        game_req   = 1'b1;
        game_we    = 1'b1;
        game_addr  = 16'h1234;
        game_wdata = 8'hA5;
        tick();
        chk("t2_wr_gnt", act_ggnt, 1'b1);
        game_we = 1'b0;
        tick();
        chk("t2_rd_gnt", act_ggnt, 1'b1);
        game_req = 1'b0;
        tick();
        tick();
        chk("t2_rdata", game_rdata, 8'hA5);

        // starvation forces a game grant on the 4th requested cycle
        disp_req  = 1'b1;
        disp_addr = 16'h0005;
        game_req  = 1'b1;
        game_we   = 1'b0;
        game_addr = 16'h0077;
        first = 0;
        dg_at_grant = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (act_ggnt && first == 0) begin
                first       = k;
                dg_at_grant = act_dgnt;
                game_req    = 1'b0;
            end
        end
        chk("t3_first_grant", first, 4);
        chk("t3_disp_at_grant", dg_at_grant, 1'b0);
        disp_req = 1'b0;
        tick();
        tick();
        chk("t3_game_rdata", game_rdata, 8'h77);

        // interleaved owners
        disp_req = 1'b1; disp_addr = 16'h0010;
        tick();
        disp_req = 1'b0; game_req = 1'b1; game_we = 1'b0; game_addr = 16'h0020;
        tick();
        game_req = 1'b0; disp_req = 1'b1; disp_addr = 16'h0030;
        tick();
        disp_req = 1'b0;
        tick();
        tick();
        chk("t4_disp_rdata", disp_rdata, 8'h30);
        chk("t4_game_rdata", game_rdata, 8'h20);

        // reset mid-operation with a partially starved game request
        disp_req = 1'b1; disp_addr = 16'h0042;
        game_req = 1'b1; game_we = 1'b0; game_addr = 16'h0099;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        first = 0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (act_ggnt && first == 0) begin
                first    = k;
                game_req = 1'b0;
            end
        end
        chk("t5_first_after_reset", first, 4);
        disp_req = 1'b0;
        tick();
        tick();

        // abandoned write leaves RAM untouched and clears the count
        disp_req = 1'b1; disp_addr = 16'h0001;
        game_req = 1'b1; game_we = 1'b1; game_addr = 16'h0050; game_wdata = 8'hEE;
        tick();
        tick();
        game_req = 1'b0;
        tick();
        game_req = 1'b1; game_we = 1'b0;
        first = 0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (act_ggnt && first == 0) begin
                first    = k;
                game_req = 1'b0;
            end
        end
        chk("t6_first_grant", first, 4);
        disp_req = 1'b0;
        tick();
        tick();
        chk("t6_ram_unchanged", game_rdata, 8'h50);

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            reset     = ($urandom_range(0, 63) == 0);
            disp_req  = ($urandom_range(0, 3) != 0);
            disp_addr = AW'($urandom_range(0, 255));
            if (!game_req || $urandom_range(0, 15) == 0) begin
                game_req   = $urandom_range(0, 1) != 0;
                game_we    = $urandom_range(0, 1) != 0;
                game_addr  = AW'($urandom_range(0, 255));
                game_wdata = DW'($urandom);
            end
            tick();
            if (act_ggnt) game_req = 1'b0;
        end
        reset    = 1'b0;
        disp_req = 1'b0;
        game_req = 1'b0;
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
